// File: rtl/arp_reply_gen.sv
// ARP responder: answers requests for this channel's IPv4 with a single-beat reply,
// reports sender bindings to the peer table and keeps per-class packet counters.
module arp_reply_gen #(
    parameter int C_AXIS_DATA_WIDTH = 512,
    parameter int C_AXIS_KEEP_WIDTH = 64,
    parameter int CHANNEL_NUM       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [47:0]                  local_mac,
    input  logic [31:0]                  local_ipv4,
    input  logic [C_AXIS_DATA_WIDTH-1:0] arp_s_axis_tdata,
    input  logic [C_AXIS_KEEP_WIDTH-1:0] arp_s_axis_tkeep,
    input  logic                         arp_s_axis_tvalid,
    input  logic                         arp_s_axis_tlast,
    output logic                         arp_s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0] arp_m_axis_tdata,
    output logic [C_AXIS_KEEP_WIDTH-1:0] arp_m_axis_tkeep,
    output logic                         arp_m_axis_tvalid,
    output logic                         arp_m_axis_tlast,
    input  logic                         arp_m_axis_tready,
    output logic                         peer_valid,
    output logic [47:0]                  peer_mac,
    output logic [31:0]                  peer_ip,
    output logic [15:0]                  rx_req_cnt,
    output logic [15:0]                  rx_rep_cnt,
    output logic [15:0]                  drop_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    // Input is MSB-first; the reply goes out with byte k at bits [8k+7:8k].
    function automatic logic [511:0] build_reply(
        input logic [47:0] dst_mac,
        input logic [31:0] dst_ip,
        input logic [47:0] src_mac,
        input logic [31:0] src_ip
    );
        logic [479:0] frame;
        logic [511:0] r;
        frame = {dst_mac, src_mac, 16'h0806,
                 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                 src_mac, src_ip, dst_mac, dst_ip, 144'h0};
        r = '0;
        for (int k = 0; k < 60; k++) begin
            r[8*k +: 8] = frame[479-8*k -: 8];
        end
        return r;
    endfunction

    logic [1:0]  state;
    logic        req_pend;
    logic [C_AXIS_DATA_WIDTH-1:0] reply_p1;

    logic [47:0] my_mac;
    logic [31:0] my_ip;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    logic        hdr_ok;
    logic        is_req;
    logic        is_rep;
    logic        s_hs;
    logic        first_hs;

    assign my_mac = local_mac + 48'(CHANNEL_NUM);
    assign my_ip  = local_ipv4 + 32'(CHANNEL_NUM);

    assign htype = arp_s_axis_tdata[399:384];
    assign ptype = arp_s_axis_tdata[383:368];
    assign hlen  = arp_s_axis_tdata[367:360];
    assign plen  = arp_s_axis_tdata[359:352];
    assign oper  = arp_s_axis_tdata[351:336];
    assign sha   = arp_s_axis_tdata[335:288];
    assign spa   = arp_s_axis_tdata[287:256];
    assign tpa   = arp_s_axis_tdata[207:176];

    assign hdr_ok = (htype == 16'h0001) && (ptype == 16'h0800) &&
                    (hlen == 8'h06) && (plen == 8'h04);
    assign is_req = hdr_ok && (oper == 16'h0001) && (tpa == my_ip);
    assign is_rep = hdr_ok && (oper == 16'h0002);

    assign arp_s_axis_tready = !rst && (state != ST_SEND);
    assign s_hs     = arp_s_axis_tvalid && arp_s_axis_tready;
    assign first_hs = s_hs && (state == ST_IDLE);

    assign arp_m_axis_tvalid = (state == ST_SEND);
    assign arp_m_axis_tlast  = (state == ST_SEND);
    assign arp_m_axis_tdata  = reply_p1;
    assign arp_m_axis_tkeep  = 64'h0FFF_FFFF_FFFF_FFFF;

    logic unused_inputs;
    assign unused_inputs = ^{arp_s_axis_tkeep, arp_s_axis_tdata[511:400],
                             arp_s_axis_tdata[255:208], arp_s_axis_tdata[175:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_pend   <= 1'b0;
            peer_valid <= 1'b0;
            peer_mac   <= '0;
            peer_ip    <= '0;
            rx_req_cnt <= '0;
            rx_rep_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            peer_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_hs) begin
                        req_pend <= is_req;
                        if (is_req || is_rep) begin
                            peer_valid <= 1'b1;
                            peer_mac   <= sha;
                            peer_ip    <= spa;
                        end
                        if (is_req)      rx_req_cnt <= rx_req_cnt + 16'd1;
                        else if (is_rep) rx_rep_cnt <= rx_rep_cnt + 16'd1;
                        else             drop_cnt   <= drop_cnt + 16'd1;
                        if (arp_s_axis_tlast) state <= is_req ? ST_SEND : ST_IDLE;
                        else                  state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (s_hs && arp_s_axis_tlast) state <= req_pend ? ST_SEND : ST_IDLE;
                end
                ST_SEND: begin
                    if (arp_m_axis_tready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Reply is formed from the first beat and held untouched until the next first beat.
    always_ff @(posedge clk) begin
        if (first_hs) begin
            reply_p1 <= build_reply(sha, spa, my_mac, my_ip);
        end
    end

endmodule

// File: tb/tb_arp_reply_gen.sv
// Scoreboard bench for arp_reply_gen: expected replies are queued at stimulus time
// and compared by a monitor when the DUT hands a reply off.
module tb_arp_reply_gen;

    localparam logic [47:0] LMAC  = 48'h0200_0000_0010;
    localparam logic [31:0] LIP   = 32'hC0A8_0164;
    localparam logic [47:0] MYMAC = 48'h0200_0000_0011;
    localparam logic [31:0] MYIP  = 32'hC0A8_0165;
    localparam logic [63:0] KEEP  = 64'h0FFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] s_tdata = '0;
    logic [63:0]  s_tkeep = '1;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready = 1'b1;
    logic         peer_valid;
    logic [47:0]  peer_mac;
    logic [31:0]  peer_ip;
    logic [15:0]  rx_req_cnt;
    logic [15:0]  rx_rep_cnt;
    logic [15:0]  drop_cnt;

    int errors = 0;
    int checks = 0;
    logic [511:0] sb_q[$];

    arp_reply_gen #(.C_AXIS_DATA_WIDTH(512), .C_AXIS_KEEP_WIDTH(64), .CHANNEL_NUM(1)) dut (
        .clk(clk), .rst(rst), .local_mac(LMAC), .local_ipv4(LIP),
        .arp_s_axis_tdata(s_tdata), .arp_s_axis_tkeep(s_tkeep),
        .arp_s_axis_tvalid(s_tvalid), .arp_s_axis_tlast(s_tlast),
        .arp_s_axis_tready(s_tready),
        .arp_m_axis_tdata(m_tdata), .arp_m_axis_tkeep(m_tkeep),
        .arp_m_axis_tvalid(m_tvalid), .arp_m_axis_tlast(m_tlast),
        .arp_m_axis_tready(m_tready),
        .peer_valid(peer_valid), .peer_mac(peer_mac), .peer_ip(peer_ip),
        .rx_req_cnt(rx_req_cnt), .rx_rep_cnt(rx_rep_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_pkt(input logic [15:0] oper, input logic [15:0] ptype,
                                            input logic [47:0] sha, input logic [31:0] spa,
                                            input logic [31:0] tpa);
        logic [335:0] h;
        h = {48'hFFFF_FFFF_FFFF, sha, 16'h0806, 16'h0001, ptype, 8'h06, 8'h04,
             oper, sha, spa, 48'h0, tpa};
        return {h, 176'h0};
    endfunction

    function automatic logic [511:0] exp_reply(input logic [47:0] sha, input logic [31:0] spa);
        logic [7:0]   b[60];
        logic [511:0] r;
        for (int i = 0; i < 60; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]      = sha[47-8*i -: 8];
            b[6+i]    = MYMAC[47-8*i -: 8];
            b[22+i]   = MYMAC[47-8*i -: 8];
            b[32+i]   = sha[47-8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            b[28+i] = MYIP[31-8*i -: 8];
            b[38+i] = spa[31-8*i -: 8];
        end
        b[12] = 8'h08; b[13] = 8'h06;
        b[14] = 8'h00; b[15] = 8'h01; b[16] = 8'h08; b[17] = 8'h00;
        b[18] = 8'h06; b[19] = 8'h04; b[20] = 8'h00; b[21] = 8'h02;
        r = '0;
        for (int i = 0; i < 60; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    function automatic logic [63:0] field(input logic [511:0] d, input int start, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[55:0], d[8*(start+i) +: 8]};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send_beat(input logic [511:0] d, input logic last, output int waited);
        waited = 0;
        s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
        @(negedge clk);
        while (!s_tready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 50) chk("beat_timeout", 1, 0);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_reply", 1, 0);
            end else begin
                chk("reply_frame", m_tdata, sb_q.pop_front());
                chk("reply_keep", m_tkeep, KEEP);
                chk("reply_last", m_tlast, 1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [47:0]  sha1 = 48'h0A0B_0C0D_0E0F;
        logic [31:0]  spa1 = 32'hC0A8_0102;
        logic [511:0] req1;
        logic [511:0] exp1;
        req1 = mk_pkt(16'h0001, 16'h0800, sha1, spa1, MYIP);
        exp1 = exp_reply(sha1, spa1);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", s_tready, 0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_peer_valid", peer_valid, 0);
        chk("rst_counters", {rx_req_cnt, rx_rep_cnt, drop_cnt}, 0);
        chk("rst_peer", {peer_mac, peer_ip}, 0);
        step();
        rst = 1'b0;
        step();

        // T1 single-beat request
        @(negedge clk);
        chk("t1_pre_mvalid", m_tvalid, 0);
        step();
        sb_q.push_back(exp1);
        send_beat(req1, 1'b1, w);
        @(negedge clk);
        chk("t1_mvalid", m_tvalid, 1);
        chk("t1_dst", field(m_tdata, 0, 6), 64'h0A0B_0C0D_0E0F);
        chk("t1_oper", field(m_tdata, 20, 2), 64'h0002);
        chk("t1_tpa", field(m_tdata, 38, 4), 64'hC0A8_0102);
        chk("t1_spa", field(m_tdata, 28, 4), 64'hC0A8_0165);
        chk("t1_peer_valid", peer_valid, 1);
        chk("t1_peer", {peer_mac, peer_ip}, {sha1, spa1});
        chk("t1_req_cnt", rx_req_cnt, 1);
        @(negedge clk);
        chk("t1_mvalid_drop", m_tvalid, 0);
        chk("t1_peer_pulse", peer_valid, 0);

        // T2 back-pressured reply
        step();
        m_tready = 1'b0;
        sb_q.push_back(exp1);
        send_beat(req1, 1'b1, w);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", m_tvalid, 1);
            chk("t2_hold_data", m_tdata, exp1);
            chk("t2_s_tready", s_tready, 0);
        end
        step();
        m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_after_valid", m_tvalid, 0);
        chk("t2_req_cnt", rx_req_cnt, 2);
        chk("t2_sb_empty", sb_q.size(), 0);

        // T3 foreign TPA then non-IPv4 PTYPE
        step();
        send_beat(mk_pkt(16'h0001, 16'h0800, sha1, spa1, 32'hC0A8_0199), 1'b1, w);
        @(negedge clk);
        chk("t3_drop1", drop_cnt, 1);
        chk("t3_peer_valid", peer_valid, 0);
        chk("t3_mvalid", m_tvalid, 0);
        step();
        send_beat(mk_pkt(16'h0001, 16'h86DD, sha1, spa1, MYIP), 1'b1, w);
        @(negedge clk);
        chk("t3_drop2", drop_cnt, 2);
        chk("t3_peer_valid2", peer_valid, 0);
        chk("t3_mvalid2", m_tvalid, 0);

        // T4 three-beat ARP reply is learned, no answer
        step();
        send_beat(mk_pkt(16'h0002, 16'h0800, 48'h1122_3344_5566, 32'h0A00_0007, 32'h0), 1'b0, w);
        @(negedge clk);
        chk("t4_peer_valid", peer_valid, 1);
        chk("t4_peer", {peer_mac, peer_ip}, {48'h1122_3344_5566, 32'h0A00_0007});
        chk("t4_rep_cnt", rx_rep_cnt, 1);
        chk("t4_drain_ready", s_tready, 1);
        step();
        send_beat({16{$urandom()}}, 1'b0, w);
        chk("t4_beat2_wait", w, 0);
        send_beat({16{$urandom()}}, 1'b1, w);
        chk("t4_beat3_wait", w, 0);
        @(negedge clk);
        chk("t4_mvalid", m_tvalid, 0);
        chk("t4_idle_ready", s_tready, 1);

        // T5 three-beat request answers only after tlast
        step();
        sb_q.push_back(exp_reply(48'hA1A2_A3A4_A5A6, 32'h0A0A_0A0A));
        send_beat(mk_pkt(16'h0001, 16'h0800, 48'hA1A2_A3A4_A5A6, 32'h0A0A_0A0A, MYIP), 1'b0, w);
        @(negedge clk);
        chk("t5_first_mvalid", m_tvalid, 0);
        chk("t5_req_cnt", rx_req_cnt, 3);
        step();
        send_beat({16{$urandom()}}, 1'b0, w);
        @(negedge clk);
        chk("t5_mid_mvalid", m_tvalid, 0);
        step();
        send_beat({16{$urandom()}}, 1'b1, w);
        @(negedge clk);
        chk("t5_last_mvalid", m_tvalid, 1);
        @(negedge clk);
        chk("t5_sb_empty", sb_q.size(), 0);

        // T6 reset during SEND abandons the reply
        step();
        m_tready = 1'b0;
        send_beat(req1, 1'b1, w);
        @(negedge clk);
        chk("t6_send", m_tvalid, 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_tready", s_tready, 0);
        step();
        rst = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        chk("t6_mvalid", m_tvalid, 0);
        chk("t6_counters", {rx_req_cnt, rx_rep_cnt, drop_cnt}, 0);
        step();
        sb_q.push_back(exp1);
        send_beat(req1, 1'b1, w);
        @(negedge clk);
        chk("t6_new_mvalid", m_tvalid, 1);
        chk("t6_req_cnt", rx_req_cnt, 1);
        @(negedge clk);
        chk("t6_sb_empty", sb_q.size(), 0);
        chk("t6_idle", m_tvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
